// File: rtl/spi_pkg.sv
// Shared opcodes, request encodings and sequencer states for spi_master_ctrl.
// SPI_MST_CLR_EN compiles in the clear opcode.
package spi_pkg;

  localparam logic [7:0] SPI_CMD_WR = 8'h80;
  localparam logic [7:0] SPI_CMD_RD = 8'h08;
`ifdef SPI_MST_CLR_EN
  localparam logic [7:0] SPI_CMD_CLR = 8'h55;
`endif

  typedef enum logic [1:0] {
    REQ_WR   = 2'd0,
    REQ_RD   = 2'd1,
    REQ_CLR  = 2'd2,
    REQ_RSVD = 2'd3
  } req_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// One SPI byte (CPOL=0/CPHA=1): low half then high half per bit, MOSI changes on
// the rising edge, MISO captured on the falling edge; restarts seamlessly on start.
module spi_byte_shifter #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       spi_miso_i,
  output logic       load,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       spi_clk_o,
  output logic       spi_mosi_o
);

  localparam int unsigned HW = $clog2(CLK_DIV);

  logic          active_q;
  logic [HW-1:0] hcnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    tx_q, rx_q, tx_src;
  logic          sclk_q, mosi_q;
  logic          half_end;

  assign half_end   = active_q && (hcnt_q == HW'(CLK_DIV - 1));
  // tx_byte is only needed on the cycle before the first rising edge
  assign load       = half_end && !sclk_q && (bit_q == 3'd0);
  assign byte_done  = half_end && sclk_q && (bit_q == 3'd7);
  assign rx_byte    = {rx_q[6:0], spi_miso_i};
  assign tx_src     = (bit_q == 3'd0) ? tx_byte : tx_q;
  assign spi_clk_o  = sclk_q;
  assign spi_mosi_o = mosi_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      hcnt_q   <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      if (active_q) begin
        if (half_end) begin
          hcnt_q <= '0;
          sclk_q <= !sclk_q;
          if (!sclk_q) begin
            mosi_q <= tx_src[7];
            tx_q   <= {tx_src[6:0], 1'b0};
          end else begin
            rx_q  <= rx_byte;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) active_q <= start;
          end
        end else begin
          hcnt_q <= hcnt_q + HW'(1);
        end
      end else if (start) begin
        active_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: csn framing, command/address/data bytes to the slave register memory.
// SPI_MST_CLR_EN enables the one-byte clear frame for req_cmd 2.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned CS_SETUP = 8,
  parameter int unsigned CS_HOLD  = 8
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic [1:0] req_cmd_i,
  input  logic [7:0] req_addr_i,
  input  logic [3:0] req_len_i,
  output logic       req_ack_o,
  input  logic [7:0] wr_data_i,
  output logic       wr_data_rd_o,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       spi_csn_o,
  output logic       spi_clk_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i
);

  state_e     state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  nbyte_q, nbyte_d;
  req_cmd_e    cmd_q;
  logic [7:0]  addr_q;
  logic [3:0]  len_q;
  logic        ack_q, ack_d, done_q, done_d, busy_q, busy_d, csn_q, csn_d;
  logic        rd_valid_q;
  logic [7:0]  rd_data_q;
  logic        start, load, byte_done, sh_clk, sh_mosi, spi_req;
  logic [7:0]  tx_byte, rx_byte, opcode;

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .start      (start),
    .tx_byte    (tx_byte),
    .spi_miso_i (spi_miso_i),
    .load       (load),
    .byte_done  (byte_done),
    .rx_byte    (rx_byte),
    .spi_clk_o  (sh_clk),
    .spi_mosi_o (sh_mosi)
  );

  always_comb begin
    spi_req = (req_cmd_i == REQ_WR) || (req_cmd_i == REQ_RD);
`ifdef SPI_MST_CLR_EN
    spi_req = spi_req || (req_cmd_i == REQ_CLR);
`endif
  end

  always_comb begin
    opcode = SPI_CMD_WR;
    if (cmd_q == REQ_RD) opcode = SPI_CMD_RD;
`ifdef SPI_MST_CLR_EN
    else if (cmd_q == REQ_CLR) opcode = SPI_CMD_CLR;
`endif
  end

  always_comb begin
    case (state_q)
      ST_ADDR: tx_byte = addr_q;
      ST_DATA: tx_byte = (cmd_q == REQ_WR) ? wr_data_i : '0;
      default: tx_byte = opcode;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nbyte_d = nbyte_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    csn_d   = csn_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: if (req_i) begin
        ack_d   = 1'b1;
        busy_d  = 1'b1;
        cnt_d   = '0;
        nbyte_d = '0;
        if (spi_req) begin
          csn_d   = 1'b0;
          state_d = ST_SETUP;
        end else begin
          // frameless command: reuse GAP, preloaded so done lands 2 cycles after ack
          state_d = ST_GAP;
          cnt_d   = 16'(CS_HOLD - 2);
        end
      end
      ST_SETUP: if (cnt_q == 16'(CS_SETUP - 1)) begin
        start   = 1'b1;
        state_d = ST_CMD;
      end else cnt_d = cnt_q + 16'd1;
      ST_CMD: if (byte_done) begin
        if ((cmd_q == REQ_WR) || (cmd_q == REQ_RD)) begin
          start   = 1'b1;
          state_d = ST_ADDR;
        end else begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_ADDR: if (byte_done) begin
        start   = 1'b1;
        nbyte_d = '0;
        state_d = ST_DATA;
      end
      ST_DATA: if (byte_done) begin
        if (nbyte_q == len_q) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          start   = 1'b1;
          nbyte_d = nbyte_q + 4'd1;
        end
      end
      ST_HOLD: if (cnt_q == 16'(CS_HOLD - 1)) begin
        csn_d   = 1'b1;
        cnt_d   = '0;
        state_d = ST_GAP;
      end else cnt_d = cnt_q + 16'd1;
      ST_GAP: if (cnt_q == 16'(CS_HOLD - 1)) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end else cnt_d = cnt_q + 16'd1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nbyte_q    <= '0;
      cmd_q      <= REQ_WR;
      addr_q     <= '0;
      len_q      <= '0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      csn_q      <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbyte_q    <= nbyte_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      csn_q      <= csn_d;
      rd_valid_q <= byte_done && (state_q == ST_DATA) && (cmd_q == REQ_RD);
      if (state_q == ST_IDLE && req_i) begin
        cmd_q  <= req_cmd_e'(req_cmd_i);
        addr_q <= req_addr_i;
        len_q  <= req_len_i;
      end
      if (byte_done && (state_q == ST_DATA) && (cmd_q == REQ_RD)) rd_data_q <= rx_byte;
    end
  end

  assign req_ack_o    = ack_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign wr_data_rd_o = load && (state_q == ST_DATA) && (cmd_q == REQ_WR);
  assign spi_csn_o    = csn_q;
  assign spi_clk_o    = sh_clk;
  assign spi_mosi_o   = sh_mosi & ~csn_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl with a behavioural SPI slave memory.
// Clear-frame expectations follow SPI_MST_CLR_EN.
module tb_spi_master_ctrl;

  localparam int unsigned CLK_DIV  = 8;
  localparam int unsigned CS_SETUP = 8;
  localparam int unsigned CS_HOLD  = 8;

  logic       clk_i = 1'b0, rst_n = 1'b0, req_i = 1'b0;
  logic [1:0] req_cmd_i = '0;
  logic [7:0] req_addr_i = '0, wr_data_i = '0;
  logic [3:0] req_len_i = '0;
  logic       req_ack_o, wr_data_rd_o, rd_valid_o, busy_o, done_o;
  logic [7:0] rd_data_o;
  logic       spi_csn_o, spi_clk_o, spi_mosi_o, spi_miso_i = 1'b0;

  always #5 clk_i = ~clk_i;

  spi_master_ctrl #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .req_i(req_i), .req_cmd_i(req_cmd_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_ack_o(req_ack_o),
    .wr_data_i(wr_data_i), .wr_data_rd_o(wr_data_rd_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .busy_o(busy_o), .done_o(done_o),
    .spi_csn_o(spi_csn_o), .spi_clk_o(spi_clk_o), .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(spi_miso_i)
  );

  int unsigned total = 0, passed = 0;
  logic [7:0]  mem [256];
  logic [7:0]  exp_mem [256];
  logic [7:0]  mosi_log[$], rd_log[$], wq[$];
  int unsigned wr_pulses = 0, wr_base = 0, ack_cnt = 0, done_cnt = 0, csn_falls = 0, sclk_viol = 0;

  // Behavioural slave: cmd byte, addr byte, then data burst with wrapping address.
  initial begin
    logic [7:0]  rx_sh, tx_sh, s_cmd, s_addr;
    int unsigned s_bit, s_byte;
    logic        prev_clk;
    rx_sh = '0; tx_sh = '0; s_cmd = '0; s_addr = '0; s_bit = 0; s_byte = 0; prev_clk = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(spi_clk_o or spi_csn_o);
      if (spi_csn_o !== 1'b0) begin
        s_bit = 0; s_byte = 0;
      end else if (spi_clk_o === 1'b1 && prev_clk === 1'b0) begin
        spi_miso_i = tx_sh[7];
        tx_sh = {tx_sh[6:0], 1'b0};
      end else if (spi_clk_o === 1'b0 && prev_clk === 1'b1) begin
        rx_sh = {rx_sh[6:0], spi_mosi_o};
        s_bit++;
        if (s_bit == 8) begin
          s_bit = 0;
          mosi_log.push_back(rx_sh);
          if (s_byte == 0) begin
            s_cmd = rx_sh;
            if (rx_sh == 8'h55) for (int i = 0; i < 256; i++) mem[i] = 8'h00;
          end else if (s_byte == 1) begin
            s_addr = rx_sh;
            if (s_cmd == 8'h08) tx_sh = mem[s_addr];
          end else begin
            if (s_cmd == 8'h80) mem[s_addr] = rx_sh;
            s_addr = s_addr + 8'd1;
            if (s_cmd == 8'h08) tx_sh = mem[s_addr];
          end
          s_byte++;
        end
      end
      prev_clk = spi_clk_o;
    end
  end

  // Cycle monitor: write-data supply, pulse counting, clk-while-csn-high watch.
  initial begin
    logic prev_csn;
    prev_csn = 1'b1;
    forever begin
      @(negedge clk_i);
      if (spi_csn_o === 1'b1 && spi_clk_o !== 1'b0) sclk_viol++;
      wr_data_i = ((wr_pulses - wr_base) < wq.size()) ? wq[wr_pulses - wr_base] : 8'h00;
      if (wr_data_rd_o === 1'b1) wr_pulses++;
      if (rd_valid_o === 1'b1) rd_log.push_back(rd_data_o);
      if (req_ack_o === 1'b1) ack_cnt++;
      if (done_o === 1'b1) done_cnt++;
      if (spi_csn_o === 1'b0 && prev_csn === 1'b1) csn_falls++;
      prev_csn = spi_csn_o;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] log[$], input int unsigned base,
                              input logic [7:0] exp[$]);
    int unsigned n;
    check({tag, "_len"}, log.size() - base, exp.size());
    n = ((log.size() - base) < exp.size()) ? (log.size() - base) : exp.size();
    for (int unsigned i = 0; i < n; i++) check({tag, "_byte"}, log[base + i], exp[i]);
  endtask

  task automatic wait_ack();
    int unsigned t;
    t = 0;
    do begin @(negedge clk_i); t++; end while (req_ack_o !== 1'b1 && t < 20);
    check("ack_seen", req_ack_o, 1);
  endtask

  task automatic do_req(input logic [1:0] cmd, input logic [7:0] addr, input logic [3:0] len,
                        output int unsigned lat);
    int unsigned t;
    wr_base = wr_pulses;
    @(negedge clk_i);
    req_i = 1'b1; req_cmd_i = cmd; req_addr_i = addr; req_len_i = len;
    wait_ack();
    req_i = 1'b0; req_cmd_i = 2'($urandom); req_addr_i = 8'($urandom); req_len_i = 4'($urandom);
    t = 0;
    while (done_o !== 1'b1 && t < 5000) begin @(negedge clk_i); t++; end
    lat = t;
    check("done_seen", done_o, 1);
    check("busy_at_done", busy_o, 0);
    @(negedge clk_i);
  endtask

  // Reference: expected MOSI stream, memory image, read bytes and cycle count per request.
  task automatic txn(input logic [1:0] cmd, input logic [7:0] addr, input logic [3:0] len);
    logic [7:0]  exp_mosi[$], exp_rd[$];
    logic [7:0]  a;
    int unsigned nb, lat, mb, rb, wb;
    nb = int'(len) + 1;
    exp_mosi.push_back(cmd == 2'd0 ? 8'h80 : 8'h08);
    exp_mosi.push_back(addr);
    a = addr;
    for (int unsigned i = 0; i < nb; i++) begin
      if (cmd == 2'd0) begin exp_mosi.push_back(wq[i]); exp_mem[a] = wq[i]; end
      else begin exp_mosi.push_back(8'h00); exp_rd.push_back(exp_mem[a]); end
      a = a + 8'd1;
    end
    mb = mosi_log.size(); rb = rd_log.size(); wb = wr_pulses;
    do_req(cmd, addr, len, lat);
    check("latency", lat, CS_SETUP + (nb + 2) * 16 * CLK_DIV + 2 * CS_HOLD);
    check_stream("mosi", mosi_log, mb, exp_mosi);
    check_stream("rd_data", rd_log, rb, exp_rd);
    check("wr_pulses", wr_pulses - wb, (cmd == 2'd0) ? nb : 0);
  endtask

  initial begin
    int unsigned lat, t, extra_acks, mb, cf, d0;
    logic [7:0]  exp_q[$];
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;

    repeat (4) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    check("rst_csn", spi_csn_o, 1);
    check("rst_clk", spi_clk_o, 0);
    check("rst_mosi", spi_mosi_o, 0);
    check("rst_rd_data", rd_data_o, 8'h00);
    check("rst_busy", busy_o, 0);
    check("rst_pulses", {req_ack_o, done_o, rd_valid_o, wr_data_rd_o}, 4'b0000);

    // Directed write/read of three bytes at 0x10
    wq = {8'hA1, 8'hB2, 8'hC3};
    txn(2'd0, 8'h10, 4'd2);
    check("mem_10", mem[8'h10], 8'hA1);
    check("mem_11", mem[8'h11], 8'hB2);
    check("mem_12", mem[8'h12], 8'hC3);
    txn(2'd1, 8'h10, 4'd2);
    check("rd_data_last", rd_data_o, 8'hC3);

    // Request held high across a transaction
    wq = {8'h5A}; exp_mem[8'h20] = 8'h5A; wr_base = wr_pulses;
    @(negedge clk_i);
    req_i = 1'b1; req_cmd_i = 2'd0; req_addr_i = 8'h20; req_len_i = 4'd0;
    wait_ack();
    req_cmd_i = 2'd1;
    extra_acks = 0; t = 0;
    while (done_o !== 1'b1 && t < 5000) begin
      @(negedge clk_i); t++;
      if (req_ack_o === 1'b1) extra_acks++;
    end
    check("held_done", done_o, 1);
    check("held_single_ack", extra_acks, 0);
    t = 0;
    do begin @(negedge clk_i); t++; end while (req_ack_o !== 1'b1 && t < 20);
    check("held_second_ack_delay", t, 1);
    req_i = 1'b0;
    mb = rd_log.size(); t = 0;
    while (done_o !== 1'b1 && t < 5000) begin @(negedge clk_i); t++; end
    @(negedge clk_i);
    exp_q = {8'h5A};
    check_stream("held_rd", rd_log, mb, exp_q);

    // Clear and reserved commands
    cf = csn_falls; mb = mosi_log.size();
    do_req(2'd2, 8'h00, 4'd0, lat);
`ifdef SPI_MST_CLR_EN
    check("clr_latency", lat, CS_SETUP + 16 * CLK_DIV + 2 * CS_HOLD);
    check("clr_csn_frames", csn_falls - cf, 1);
    exp_q = {8'h55};
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
`else
    check("clr_latency", lat, 2);
    check("clr_csn_frames", csn_falls - cf, 0);
    exp_q = {};
`endif
    check_stream("clr_mosi", mosi_log, mb, exp_q);
    cf = csn_falls;
    do_req(2'd3, 8'h00, 4'd0, lat);
    check("rsvd_latency", lat, 2);
    check("rsvd_csn_frames", csn_falls - cf, 0);

    // Reset in the middle of the first data byte
    wq = {8'h11, 8'h22, 8'h33, 8'h44}; wr_base = wr_pulses; d0 = done_cnt;
    @(negedge clk_i);
    req_i = 1'b1; req_cmd_i = 2'd0; req_addr_i = 8'h40; req_len_i = 4'd3;
    wait_ack();
    req_i = 1'b0;
    repeat (CS_SETUP + 2 * 16 * CLK_DIV + CLK_DIV + 3) @(negedge clk_i);
    check("abort_pre_busy", busy_o, 1);
    check("abort_pre_clk", spi_clk_o, 1);
    rst_n = 1'b0;
    @(posedge clk_i); #1;
    check("abort_csn", spi_csn_o, 1);
    check("abort_clk", spi_clk_o, 0);
    check("abort_mosi", spi_mosi_o, 0);
    check("abort_busy", busy_o, 0);
    @(negedge clk_i);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_i);
    check("abort_no_done", done_cnt - d0, 0);
    wq = {8'($urandom), 8'($urandom)};
    txn(2'd0, 8'h30, 4'd1);
    txn(2'd1, 8'h30, 4'd1);

    // Address wrap inside the slave
    wq = {8'($urandom), 8'($urandom)};
    txn(2'd0, 8'hFF, 4'd1);
    check("wrap_mem_ff", mem[8'hFF], exp_mem[8'hFF]);
    check("wrap_mem_00", mem[8'h00], exp_mem[8'h00]);
    txn(2'd1, 8'hFF, 4'd1);

    // Randomized writes and reads against the reference memory
    for (int n = 0; n < 6; n++) begin
      logic [1:0] c;
      logic [7:0] ad;
      logic [3:0] ln;
      c  = 2'($urandom_range(0, 1));
      ad = 8'($urandom);
      ln = 4'($urandom);
      wq = {};
      for (int unsigned i = 0; i <= ln; i++) wq.push_back(8'($urandom));
      txn(c, ad, ln);
    end

    check("clk_low_while_csn_high", sclk_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
